// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared encodings and the EX/MEM register layout for the MEM stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        DSIZE_WORD = 2'b00,
        DSIZE_HALF = 2'b01,
        DSIZE_BYTE = 2'b10,
        DSIZE_RSVD = 2'b11
    } dsize_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    typedef struct packed {
        logic        mem_wr;
        logic        mem_to_reg;
        logic        reg_wr;
        logic        branch;
        logic        zero;
        logic        jump;
        logic        jal;
        logic        loadext;
        dsize_e      dsize;
        logic [31:0] alu_out;
        logic [31:0] bus_b;
        logic [31:0] branch_target;
        logic [31:0] delayslot2;
        logic [4:0]  rw;
    } exmem_t;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// load_align : big-endian lane select and zero/sign extension of load data
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  dsize_e      dsize,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

        case (dsize)
            DSIZE_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            DSIZE_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:    data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : EX/MEM pipeline register, data-memory handshake, fault handling
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dMemWr,
    input  logic        dMemToReg,
    input  logic        dRegWr,
    input  logic        dBranch,
    input  logic        dZero,
    input  logic        dJump,
    input  logic        dJal,
    input  logic        dLoadext,
    input  logic [1:0]  dDsize,
    input  logic [31:0] dALUout,
    input  logic [31:0] dBusB,
    input  logic [31:0] dBranchTarget,
    input  logic [31:0] dDelayslot2,
    input  logic [4:0]  dRw,
    output logic        MemToReg,
    output logic        RegWr,
    output logic        Jal,
    output logic [4:0]  Rw,
    output logic [31:0] ALUout,
    output logic [31:0] MemData,
    output logic [31:0] Delayslot2,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        Stall,
    output logic        MemFault
);

    localparam int CW = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;

    exmem_t          ex_d, ex_q;
    state_e          state, state_nx;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     mdata_q, load_fmt;
    logic [3:0]      be_lanes;
    logic            memop, misaligned, ack, fault, timeout_hit;

    assign ex_d = '{mem_wr: dMemWr, mem_to_reg: dMemToReg, reg_wr: dRegWr,
                    branch: dBranch, zero: dZero, jump: dJump, jal: dJal,
                    loadext: dLoadext, dsize: dsize_e'(dDsize), alu_out: dALUout,
                    bus_b: dBusB, branch_target: dBranchTarget,
                    delayslot2: dDelayslot2, rw: dRw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (!Stall) begin
            ex_q <= ex_d;
        end
    end

    assign memop = ex_q.mem_wr | ex_q.mem_to_reg;
    assign ack   = mem_req & mem_ack;
    // wait_cnt excludes the issuing IDLE cycle and the current cycle
    assign timeout_hit = (int'(wait_cnt) + 2 >= TIMEOUT);

    always_comb begin
        case (ex_q.dsize)
            DSIZE_HALF: misaligned = ex_q.alu_out[0];
            DSIZE_WORD: misaligned = |ex_q.alu_out[1:0];
            DSIZE_BYTE: misaligned = 1'b0;
            default:    misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state != ST_WAIT) begin
                wait_cnt <= '0;
            end else if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        fault    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memop && !misaligned) begin
                    mem_req = 1'b1;
                    if (!mem_ack) state_nx = ST_WAIT;
                end else if (memop) begin
                    fault = 1'b1;
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack)          state_nx = ST_IDLE;
                else if (timeout_hit) state_nx = ST_FAULT;
            end
            ST_FAULT: begin
                fault    = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        be_lanes  = 4'b1111;
        mem_wdata = ex_q.bus_b;
        case (ex_q.dsize)
            DSIZE_BYTE: begin
                be_lanes  = 4'b1000 >> ex_q.alu_out[1:0];
                mem_wdata = {4{ex_q.bus_b[7:0]}};
            end
            DSIZE_HALF: begin
                be_lanes  = ex_q.alu_out[1] ? 4'b0011 : 4'b1100;
                mem_wdata = {2{ex_q.bus_b[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .rdata    (mem_rdata),
        .dsize    (ex_q.dsize),
        .offset   (ex_q.alu_out[1:0]),
        .sign_ext (ex_q.loadext),
        .data     (load_fmt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdata_q <= '0;
        end else if (ack) begin
            mdata_q <= load_fmt;
        end
    end

    assign Stall        = mem_req & ~mem_ack;
    assign MemFault     = fault;
    assign mem_be       = mem_req ? be_lanes : 4'b0000;
    assign mem_addr     = {ex_q.alu_out[31:2], 2'b00};
    assign mem_we       = ex_q.mem_wr;
    assign MemData      = ack ? load_fmt : mdata_q;
    assign RegWr        = ex_q.reg_wr & ~fault;
    assign MemToReg     = ex_q.mem_to_reg & ~fault;
    assign PCSrc        = ((ex_q.branch & ex_q.zero) | ex_q.jump) & ~Stall;
    assign BranchTarget = ex_q.branch_target;
    assign ALUout       = ex_q.alu_out;
    assign Rw           = ex_q.rw;
    assign Jal          = ex_q.jal;
    assign Delayslot2   = ex_q.delayslot2;

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports, in order: clk in 1 (single clock, rising edge); rst_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL accept EX outputs: dMemWr, dMemToReg, dRegWr, dBranch, dZero, dJump, dJal, dLoadext in 1 each; dDsize in 2 (00 word, 01 half, 10 byte, 11 reserved); dALUout, dBusB, dBranchTarget, dDelayslot2 in 32; dRw in 5.
REQ-003 SHALL drive WB outputs: MemToReg, RegWr, Jal out 1; Rw out 5; ALUout, MemData, Delayslot2 out 32.
REQ-004 SHALL drive fetch control: PCSrc out 1 (branch taken); BranchTarget out 32.
REQ-005 SHALL drive the data-memory port: mem_req, mem_we out 1; mem_addr, mem_wdata out 32; mem_be out 4; mem_rdata in 32; mem_ack in 1.
REQ-006 SHALL drive Stall out 1 (freezes IF/ID/EX) and MemFault out 1 (misaligned or timeout).
REQ-007 SHALL use parameter TIMEOUT, default 15, meaning max cycles waiting for mem_ack.

Function
REQ-008 SHALL capture all d* inputs into the EX/MEM register on rising clk when Stall=0; SHALL hold them when Stall=1.
REQ-009 SHALL define memop = registered MemWr OR MemToReg.
REQ-010 SHALL implement FSM IDLE, WAIT, FAULT: IDLE->WAIT when memop and aligned; WAIT->IDLE on mem_ack; WAIT->FAULT when counter reaches TIMEOUT without ack; FAULT->IDLE after one cycle.
REQ-011 SHALL assert mem_req combinationally in IDLE (memop, aligned, not just completed) and throughout WAIT; mem_req held stable (addr/we/be/wdata constant) until mem_ack.
REQ-012 SHALL assert Stall = mem_req AND NOT mem_ack; a zero-wait ack (same cycle as request) SHALL give no stall.
REQ-013 SHALL set mem_addr = {ALUout[31:2],2'b00}, mem_we = registered MemWr.
REQ-014 SHALL use big-endian lanes: byte offset 0 -> mem_be 1000 (bits 31:24), offset 3 -> 0001; half offset 0 -> 1100, offset 2 -> 0011; word -> 1111.
REQ-015 SHALL replicate store data: byte -> BusB[7:0] to all four lanes; half -> BusB[15:0] to both halves; word -> BusB.
REQ-016 SHALL format loads from mem_rdata selected lane, zero-extended if Loadext=0, sign-extended if Loadext=1; word loads pass through.
REQ-017 SHALL present MemData formatted combinationally in the mem_ack cycle and hold it in a data register afterwards until the next register load.
REQ-018 SHALL treat misalignment (half with ALUout[0]=1; word with ALUout[1:0]!=0; Dsize=11 with memop) as fault: no mem_req, MemFault=1 for one cycle, RegWr and MemToReg outputs forced 0.
REQ-019 SHALL on timeout deassert mem_req, pulse MemFault in FAULT, force RegWr=0, and release Stall.
REQ-020 SHALL count wait cycles in a 4-bit minimum counter cleared on entering WAIT; counter saturates, never wraps.
REQ-021 SHALL drive PCSrc = registered (Branch AND Zero) OR Jump; PCSrc SHALL be 0 while Stall=1.
REQ-022 SHALL pass ALUout, Rw, Jal, Delayslot2, BranchTarget from the register unchanged.
REQ-023 SHALL ignore mem_ack when mem_req=0.

Reset
REQ-024 SHALL on rst_n=0 immediately clear all register fields, data register and counter to 0 and enter IDLE; all outputs 0.
REQ-025 SHALL abandon an in-flight access on mid-WAIT reset; mem_req falls asynchronously.

Structure
REQ-026 SHALL place Dsize encodings, FSM state encodings and TIMEOUT default in shared package mips_pkg.
REQ-027 SHALL implement lane select/extension in one combinational sub-module load_align.

Verification
REQ-028 Word store ALUout=0x100, BusB=0xDEADBEEF, ack after 2 cycles -> mem_be=1111, wdata=0xDEADBEEF, Stall=1 for 2 cycles, RegWr=0.
REQ-029 Byte load ALUout=0x103, Loadext=1, rdata=0x000000F0, zero-wait ack -> mem_be=0001, MemData=0xFFFFFFF0, Stall never 1.
REQ-030 Half load ALUout=0x102, Loadext=0, rdata=0x1234ABCD -> mem_be=0011, MemData=0x0000ABCD.
REQ-031 Word load ALUout=0x101 -> mem_req stays 0, MemFault one-cycle pulse, RegWr=0.
REQ-032 Load with ack never arriving -> Stall for 15 cycles, then MemFault pulse, Stall=0; rst_n low during WAIT -> mem_req=0 immediately.
REQ-033 Branch=1, Zero=1, BranchTarget=0x40 with no memop -> PCSrc=1, BranchTarget=0x40 one cycle after capture.
